dwt1d_haar_stream: RTL and testbench

- Parametrised streaming 1-D forward integer Haar (S-transform) lifting DWT with LEVELS decomposition levels, for 1-D sample streams.
- Generalises the fixed 8-bit, three-level, free-running schedule to configurable width and depth, with valid/ready back-pressure and tagged outputs.
- One shared lifting engine is time-multiplexed across levels, one operation per cycle.
- Sits between the sample source and the coefficient packer/quantiser.

---
 rtl/dwt_pkg.sv | 27 ++
 rtl/dwt1d_haar_stream.sv | 152 +++++++++++++++
 tb/tb_dwt1d_haar_stream.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwt_pkg.sv
// Shared definitions for the streaming Haar lifting DWT: band tags, the lifting
// kernel and elaboration-time parameter legality.
package dwt_pkg;

  localparam logic BAND_L = 1'b0;
  localparam logic BAND_H = 1'b1;

  typedef struct packed {
    logic signed [31:0] h;
    logic signed [31:0] l;
  } lift_t;

  // Operands arrive zero-extended; 32 bits leaves headroom for DATA_W+2 up to DATA_W=30.
  function automatic lift_t haar_lift(input logic signed [31:0] e,
                                      input logic signed [31:0] o);
    lift_t r;
    r.h = o - e;
    r.l = e + ($signed(r.h) >>> 1);
    return r;
  endfunction

  function automatic bit params_ok(input int data_w, input int levels, input int lvl_w);
    return (levels >= 1) && (levels <= 7) && (data_w >= 1) && (data_w <= 30) &&
           (lvl_w >= $clog2(levels + 1));
  endfunction

endpackage

// File: rtl/dwt1d_haar_stream.sv
// Streaming multi-level forward integer Haar (S-transform) DWT. A single lifting
// engine serves one source per cycle: final L, then deepest pending L, then input.
module dwt1d_haar_stream
  import dwt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEVELS = 3,
  parameter int LVL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic [LVL_W-1:0]  out_level,
  output logic              out_band
);

  if (!params_ok(DATA_W, LEVELS, LVL_W)) begin : g_param_check
    $error("dwt1d_haar_stream: illegal DATA_W/LEVELS/LVL_W combination");
  end

  // Pending slot k holds L from level k-1; slot LEVELS+1 is the final-L register F.
  logic [DATA_W-1:0] even_q [1:LEVELS];
  logic [DATA_W-1:0] even_d [1:LEVELS];
  logic [LEVELS:1]   even_v_q, even_v_d;
  logic [DATA_W-1:0] pend_q [2:LEVELS+1];
  logic [DATA_W-1:0] pend_d [2:LEVELS+1];
  logic [LEVELS+1:2] pend_v_q, pend_v_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W:0]   out_data_q, out_data_d;
  logic [LVL_W-1:0]  out_level_q, out_level_d;
  logic              out_band_q, out_band_d;

  logic              adv;
  logic              in_ready_w;
  logic              serve;
  int                src_k;
  logic [DATA_W-1:0] src_x;
  logic [DATA_W-1:0] src_e;
  logic              src_even_v;
  lift_t             lift;
  logic              unused_lift_bits;

  assign adv        = !out_valid_q || out_ready;
  assign in_ready_w = !reset && !clear && adv && (pend_v_q == '0);
  assign in_ready   = in_ready_w;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_level = out_level_q;
  assign out_band  = out_band_q;

  // Source select below F: the deepest valid pending slot wins, else the input.
  always_comb begin
    src_k      = 1;
    src_x      = in_data;
    serve      = in_valid && in_ready_w;
    src_e      = '0;
    src_even_v = 1'b0;
    for (int j = 2; j <= LEVELS; j++) begin
      if (pend_v_q[j]) begin
        src_k = j;
        src_x = pend_q[j];
        serve = 1'b1;
      end
    end
    for (int j = 1; j <= LEVELS; j++) begin
      if (j == src_k) begin
        src_e      = even_q[j];
        src_even_v = even_v_q[j];
      end
    end
  end

  assign lift = haar_lift(32'(src_e), 32'(src_x));
  assign unused_lift_bits = ^{lift.h[31:DATA_W+1], lift.l[31:DATA_W]};

  always_comb begin
    even_d      = even_q;
    even_v_d    = even_v_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_level_d = out_level_q;
    out_band_d  = out_band_q;

    if (clear) begin
      even_v_d    = '0;
      pend_v_d    = '0;
      out_valid_d = 1'b0;
    end else if (adv) begin
      out_valid_d = 1'b0;
      if (pend_v_q[LEVELS+1]) begin
        out_valid_d           = 1'b1;
        out_data_d            = {1'b0, pend_q[LEVELS+1]};
        out_level_d           = LVL_W'(LEVELS);
        out_band_d            = BAND_L;
        pend_v_d[LEVELS+1]    = 1'b0;
      end else if (serve) begin
        for (int j = 2; j <= LEVELS; j++) begin
          if (j == src_k) pend_v_d[j] = 1'b0;
        end
        for (int j = 1; j <= LEVELS; j++) begin
          if (j == src_k) begin
            if (!src_even_v) begin
              even_d[j]   = src_x;
              even_v_d[j] = 1'b1;
            end else begin
              out_valid_d   = 1'b1;
              out_data_d    = lift.h[DATA_W:0];
              out_level_d   = LVL_W'(j);
              out_band_d    = BAND_H;
              even_v_d[j]   = 1'b0;
              pend_d[j+1]   = lift.l[DATA_W-1:0];
              pend_v_d[j+1] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 1; j <= LEVELS; j++) even_q[j] <= '0;
      for (int j = 2; j <= LEVELS + 1; j++) pend_q[j] <= '0;
      even_v_q    <= '0;
      pend_v_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_level_q <= '0;
      out_band_q  <= 1'b0;
    end else begin
      for (int j = 1; j <= LEVELS; j++) even_q[j] <= even_d[j];
      for (int j = 2; j <= LEVELS + 1; j++) pend_q[j] <= pend_d[j];
      even_v_q    <= even_v_d;
      pend_v_q    <= pend_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_level_q <= out_level_d;
      out_band_q  <= out_band_d;
    end
  end

endmodule

// File: tb/tb_dwt1d_haar_stream.sv
// Scoreboard bench for dwt1d_haar_stream: directed vectors push expected
// coefficients, a negedge monitor pops and compares on every handshake.
module tb_dwt1d_haar_stream;

  localparam int DW = 8;
  localparam int LV = 3;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   out_data;
  logic [LW-1:0] out_level;
  logic          out_band;

  logic          clear2 = 1'b0;
  logic          in2_valid = 1'b0;
  logic          in2_ready;
  logic [11:0]   in2_data = '0;
  logic          out2_valid;
  logic          out2_ready = 1'b1;
  logic [12:0]   out2_data;
  logic [LW-1:0] out2_level;
  logic          out2_band;

  dwt1d_haar_stream #(.DATA_W(DW), .LEVELS(LV), .LVL_W(LW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_level(out_level), .out_band(out_band)
  );

  dwt1d_haar_stream #(.DATA_W(12), .LEVELS(1), .LVL_W(LW)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
    .out_level(out2_level), .out_band(out2_band)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int band;
    int val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   bp_mode = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void push(input int l, input int b, input int v);
    exp_t e;
    e.lvl  = l;
    e.band = b;
    e.val  = v;
    q.push_back(e);
  endfunction

  task automatic push_ramp();
    push(1, 1, 10); push(1, 1, 10); push(2, 1, 20); push(1, 1, 10);
    push(1, 1, 10); push(2, 1, 20); push(3, 1, 40); push(3, 0, 45);
  endtask

  // out_ready either stays high or toggles every cycle.
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? ~out_ready : 1'b1;
  end

  logic          hold_v = 1'b0;
  logic [DW:0]   hold_d;
  logic [LW-1:0] hold_l;
  logic          hold_b;

  always @(negedge clk) begin
    exp_t e;
    if (reset || clear) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(hold_d));
        check("stall_level", int'(out_level), int'(hold_l));
        check("stall_band", int'(out_band), int'(hold_b));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", int'(in_ready), 0);
        hold_v = 1'b1;
        hold_d = out_data;
        hold_l = out_level;
        hold_b = out_band;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got level %0d band %0d value %0d, expected no output",
                   out_level, out_band, $signed(out_data));
        end else begin
          e = q.pop_front();
          check("out_level", int'(out_level), e.lvl);
          check("out_band", int'(out_band), e.band);
          check("out_data", int'($signed(out_data)), e.val);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] x);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: sample %0d not accepted, expected in_ready within 200 cycles", x);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ramp(input bit gaps);
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i * 10));
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still missing, expected 0", q.size());
      q.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_level"}, int'(out_level), 0);
    check({tag, "_out_band"}, int'(out_band), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_out2_valid", int'(out2_valid), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ramp, free-flowing output
    push_ramp();
    send_ramp(1'b0);
    drain();

    // Sign and range, then discard the residue
    push(1, 1, -200); push(1, 1, 255); push(2, 1, 27); push(1, 1, -1);
    send(200); send(0); send(0); send(255); send(5); send(4);
    drain();
    pulse_clear();

    // Flush: partial state must not pair with the following ramp
    push(1, 1, 10);
    send(10); send(20); send(30);
    drain();
    pulse_clear();
    push_ramp();
    send_ramp(1'b0);
    drain();

    // Back-pressure with input gaps
    bp_mode = 1'b1;
    push_ramp();
    send_ramp(1'b1);
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset after the fifth ramp sample
    push(1, 1, 10); push(1, 1, 10); push(2, 1, 20);
    for (int i = 1; i <= 5; i++) send(DW'(i * 10));
    reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    check("midreset_pending_outs", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_ramp();
    send_ramp(1'b0);
    drain();

    // LEVELS=1, DATA_W=12 instance: H then L on consecutive cycles
    in2_valid = 1'b1;
    in2_data  = 12'd4095;
    @(negedge clk);
    check("l1_in_ready_a", int'(in2_ready), 1);
    @(posedge clk);
    #1;
    in2_data = 12'd0;
    @(negedge clk);
    check("l1_in_ready_b", int'(in2_ready), 1);
    check("l1_no_out_first", int'(out2_valid), 0);
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
    @(negedge clk);
    check("l1_h_valid", int'(out2_valid), 1);
    check("l1_h_level", int'(out2_level), 1);
    check("l1_h_band", int'(out2_band), 1);
    check("l1_h_data", int'($signed(out2_data)), -4095);
    check("l1_in_ready_f", int'(in2_ready), 0);
    @(negedge clk);
    check("l1_l_valid", int'(out2_valid), 1);
    check("l1_l_level", int'(out2_level), 1);
    check("l1_l_band", int'(out2_band), 0);
    check("l1_l_data", int'($signed(out2_data)), 2047);
    @(negedge clk);
    check("l1_idle_valid", int'(out2_valid), 0);
    check("l1_idle_in_ready", int'(in2_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
